// File: rtl/block_tile_sequencer.sv
// block_tile_sequencer
//   Walks a row-major (or column-major) matrix in JxK tiles. For each tile it
//   pulses bg_start to block_get and waits for bg_done. It then presents the
//   tile origin to the downstream consumer over a valid/ready handshake. One
//   sequence is run per accepted go.
//   Optional feature macro: TILE_SEQ_COLMAJOR_EN selects column-major tile order.
//   All outputs are registered. bg_start_row/col and tile_row/col share the
//   origin registers, which hold steady from the issue through the handshake.
module block_tile_sequencer #(
    parameter int J     = 2,
    parameter int K     = 2,
    parameter int DIM_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [DIM_W-1:0] num_rows,
    input  logic [DIM_W-1:0] num_cols,
    output logic             busy,
    output logic             bg_start,
    output logic [DIM_W-1:0] bg_start_row,
    output logic [DIM_W-1:0] bg_start_col,
    input  logic             bg_done,
    output logic             tile_valid,
    input  logic             tile_ready,
    output logic [DIM_W-1:0] tile_row,
    output logic [DIM_W-1:0] tile_col,
    output logic             tile_last,
    output logic             seq_done
);

    localparam logic [DIM_W:0] J_W = (DIM_W+1)'(J);
    localparam logic [DIM_W:0] K_W = (DIM_W+1)'(K);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] nrows_q, nrows_d;
    logic [DIM_W-1:0] ncols_q, ncols_d;
    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] col_q, col_d;
    logic             busy_q, busy_d;
    logic             bg_start_q, bg_start_d;
    logic             tile_valid_q, tile_valid_d;
    logic             tile_last_q, tile_last_d;
    logic             seq_done_q, seq_done_d;

    // Origin arithmetic is one bit wider so a step past the matrix edge can never wrap
    logic [DIM_W:0]   row_sum, col_sum;
    logic             row_end, col_end, last_tile;
    logic [DIM_W-1:0] next_row, next_col;

    // Edge detection and next-origin selection for the configured walk order
    always_comb begin
        row_sum   = {1'b0, row_q} + J_W;
        col_sum   = {1'b0, col_q} + K_W;
        row_end   = row_sum >= {1'b0, nrows_q};
        col_end   = col_sum >= {1'b0, ncols_q};
        last_tile = row_end && col_end;
`ifdef TILE_SEQ_COLMAJOR_EN
        // Down the column first, then step right to the next tile column
        if (row_end) begin
            next_row = '0;
            next_col = col_sum[DIM_W-1:0];
        end else begin
            next_row = row_sum[DIM_W-1:0];
            next_col = col_q;
        end
`else
        // Across the row first, then step down to the next tile row
        if (col_end) begin
            next_col = '0;
            next_row = row_sum[DIM_W-1:0];
        end else begin
            next_col = col_sum[DIM_W-1:0];
            next_row = row_q;
        end
`endif
    end

    // Sequencer next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        nrows_d      = nrows_q;
        ncols_d      = ncols_q;
        row_d        = row_q;
        col_d        = col_q;
        busy_d       = busy_q;
        bg_start_d   = 1'b0;
        tile_valid_d = tile_valid_q;
        tile_last_d  = tile_last_q;
        seq_done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    busy_d = 1'b1;
                    if (num_rows != '0 && num_cols != '0) begin
                        nrows_d    = num_rows;
                        ncols_d    = num_cols;
                        row_d      = '0;
                        col_d      = '0;
                        bg_start_d = 1'b1;
                        state_d    = S_ISSUE;
                    end else begin
                        // Empty matrix: finish straight away without touching block_get
                        seq_done_d = 1'b1;
                        state_d    = S_FIN;
                    end
                end
            end
            S_ISSUE: begin
                // bg_done in this cycle belongs to an earlier request and is not looked at
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bg_done) begin
                    tile_valid_d = 1'b1;
                    tile_last_d  = last_tile;
                    state_d      = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (tile_ready) begin
                    tile_valid_d = 1'b0;
                    tile_last_d  = 1'b0;
                    if (tile_last_q) begin
                        seq_done_d = 1'b1;
                        state_d    = S_FIN;
                    end else begin
                        row_d      = next_row;
                        col_d      = next_col;
                        bg_start_d = 1'b1;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_FIN: begin
                // go is not looked at here; busy falls on this edge
                busy_d  = 1'b0;
                row_d   = '0;
                col_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides every input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            nrows_q      <= '0;
            ncols_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            busy_q       <= 1'b0;
            bg_start_q   <= 1'b0;
            tile_valid_q <= 1'b0;
            tile_last_q  <= 1'b0;
            seq_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            nrows_q      <= nrows_d;
            ncols_q      <= ncols_d;
            row_q        <= row_d;
            col_q        <= col_d;
            busy_q       <= busy_d;
            bg_start_q   <= bg_start_d;
            tile_valid_q <= tile_valid_d;
            tile_last_q  <= tile_last_d;
            seq_done_q   <= seq_done_d;
        end
    end

    assign busy         = busy_q;
    assign bg_start     = bg_start_q;
    assign bg_start_row = row_q;
    assign bg_start_col = col_q;
    assign tile_valid   = tile_valid_q;
    assign tile_row     = row_q;
    assign tile_col     = col_q;
    assign tile_last    = tile_last_q;
    assign seq_done     = seq_done_q;

endmodule

// File: tb/tb_block_tile_sequencer.sv
// tb_block_tile_sequencer
//   Drives directed and randomized sequences. A reference model builds the
//   expected tile order with nested loops. One compare process checks every
//   cycle against that model.
module tb_block_tile_sequencer;

    localparam int J  = 2;
    localparam int K  = 2;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic [DW-1:0] num_rows = '0;
    logic [DW-1:0] num_cols = '0;
    logic          busy, bg_start, tile_valid, tile_last, seq_done;
    logic [DW-1:0] bg_start_row, bg_start_col, tile_row, tile_col;
    logic          bg_done = 1'b0;
    logic          tile_ready = 1'b0;

    block_tile_sequencer #(.J(J), .K(K), .DIM_W(DW)) dut (
        .clk(clk), .rst(rst), .go(go), .num_rows(num_rows), .num_cols(num_cols),
        .busy(busy), .bg_start(bg_start), .bg_start_row(bg_start_row),
        .bg_start_col(bg_start_col), .bg_done(bg_done), .tile_valid(tile_valid),
        .tile_ready(tile_ready), .tile_row(tile_row), .tile_col(tile_col),
        .tile_last(tile_last), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    typedef struct {int r; int c;} org_t;

    int   errors = 0;
    int   checks = 0;
    org_t exp_q[$];
    org_t log_q[$];
    int   iss_idx = 0, pres_idx = 0, done_cnt = 0;
    bit   m_active = 0, got_done = 0, hs_last_prev = 0, prev_rst = 1, first_cycle = 0;

    // stimulus knobs
    bit   rand_lat = 0, rand_ready = 0, stale_en = 0, noise = 0;
    int   hold_tile = -1, hold_cnt = 0, lat_cnt = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Expected tile origins, straight from the walk-order rules
    function automatic void build(input int rows, input int cols);
        exp_q.delete();
        if (rows == 0 || cols == 0) return;
`ifdef TILE_SEQ_COLMAJOR_EN
        for (int c = 0; c < cols; c += K)
            for (int r = 0; r < rows; r += J) exp_q.push_back('{r, c});
`else
        for (int r = 0; r < rows; r += J)
            for (int c = 0; c < cols; c += K) exp_q.push_back('{r, c});
`endif
    endfunction

    // Per-cycle compare against the model
    always @(negedge clk) begin
        bit was_active;
        bit hs_last_now;
        hs_last_now = 0;
        was_active  = m_active;
        if (prev_rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_bg_start", bg_start, 0);
            chk("rst_bg_row", int'(bg_start_row), 0);
            chk("rst_bg_col", int'(bg_start_col), 0);
            chk("rst_tile_valid", tile_valid, 0);
            chk("rst_tile_row", int'(tile_row), 0);
            chk("rst_tile_col", int'(tile_col), 0);
            chk("rst_tile_last", tile_last, 0);
            chk("rst_seq_done", seq_done, 0);
        end else begin
            chk("busy", busy, m_active);
            if (!m_active) begin
                if (bg_start)   chk("idle_bg_start", bg_start, 0);
                if (tile_valid) chk("idle_tile_valid", tile_valid, 0);
                if (seq_done)   chk("idle_seq_done", seq_done, 0);
            end else begin
                chk("seq_done", seq_done,
                    (hs_last_prev || (first_cycle && exp_q.size() == 0)) ? 1 : 0);
                if (bg_start) begin
                    chk("issue_slot", (iss_idx < exp_q.size() && iss_idx == pres_idx) ? 1 : 0, 1);
                    if (iss_idx < exp_q.size()) begin
                        chk("bg_row", int'(bg_start_row), exp_q[iss_idx].r);
                        chk("bg_col", int'(bg_start_col), exp_q[iss_idx].c);
                    end
                    iss_idx++;
                    got_done = 0;
                end else if (bg_done && iss_idx > pres_idx) begin
                    got_done = 1;
                end
                if (tile_valid) begin
                    chk("tile_after_done", (got_done && iss_idx == pres_idx + 1) ? 1 : 0, 1);
                    if (pres_idx < exp_q.size()) begin
                        chk("tile_row", int'(tile_row), exp_q[pres_idx].r);
                        chk("tile_col", int'(tile_col), exp_q[pres_idx].c);
                        chk("tile_last", tile_last, (pres_idx == exp_q.size() - 1) ? 1 : 0);
                    end
                    if (tile_ready) begin
                        log_q.push_back('{int'(tile_row), int'(tile_col)});
                        pres_idx++;
                        got_done    = 0;
                        hs_last_now = (pres_idx == exp_q.size());
                    end
                end
            end
        end
        first_cycle  = 0;
        hs_last_prev = hs_last_now;
        if (was_active && seq_done && !prev_rst) begin
            m_active = 0;
            done_cnt++;
        end
        if (rst) begin
            m_active     = 0;
            prev_rst     = 1;
            iss_idx      = 0;
            pres_idx     = 0;
            hs_last_prev = 0;
        end else begin
            prev_rst = 0;
            if (!was_active && go) begin
                build(int'(num_rows), int'(num_cols));
                log_q.delete();
                m_active    = 1;
                first_cycle = 1;
                iss_idx     = 0;
                pres_idx    = 0;
                got_done    = 0;
            end
        end
    end

    // block_get stand-in: done after a latency, optionally a stale pulse during the issue cycle
    always begin
        @(posedge clk);
        #2;
        bg_done = 1'b0;
        if (bg_start) begin
            if (stale_en && ($urandom % 2 == 0)) bg_done = 1'b1;
            lat_cnt = rand_lat ? int'($urandom_range(1, 4)) : 1;
        end else if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) bg_done = 1'b1;
        end
    end

    // Consumer: always ready, random ready, or a forced hold on one tile
    always begin
        @(posedge clk);
        #2;
        if (hold_tile >= 0 && tile_valid && pres_idx == hold_tile && hold_cnt < 5) begin
            tile_ready = 1'b0;
            hold_cnt++;
        end else begin
            tile_ready = rand_ready ? ($urandom % 3 != 0) : 1'b1;
        end
    end

    task automatic start_go(input int rows, input int cols);
        @(posedge clk);
        #2;
        go       = 1'b1;
        num_rows = DW'(rows);
        num_cols = DW'(cols);
        @(posedge clk);
        #2;
        go       = 1'b0;
        num_rows = DW'($urandom);
        num_cols = DW'($urandom);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (n < 3000) begin
            @(posedge clk);
            #2;
            if (done_cnt >= target) break;
            if (noise) begin
                go       = ($urandom % 6 == 0);
                num_rows = DW'($urandom);
                num_cols = DW'($urandom);
            end
            n++;
        end
        go = 1'b0;
        chk("seq_complete", done_cnt, target);
    endtask

    task automatic run_seq(input int rows, input int cols);
        int t;
        t = done_cnt + 1;
        start_go(rows, cols);
        wait_done(t);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 4x4 matrix, 2x2 tiles, minimum latency
        run_seq(4, 4);
        chk("t1_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk("t1_o0_r", log_q[0].r, 0); chk("t1_o0_c", log_q[0].c, 0);
`ifdef TILE_SEQ_COLMAJOR_EN
            chk("t1_o1_r", log_q[1].r, 2); chk("t1_o1_c", log_q[1].c, 0);
            chk("t1_o2_r", log_q[2].r, 0); chk("t1_o2_c", log_q[2].c, 2);
`else
            chk("t1_o1_r", log_q[1].r, 0); chk("t1_o1_c", log_q[1].c, 2);
            chk("t1_o2_r", log_q[2].r, 2); chk("t1_o2_c", log_q[2].c, 0);
`endif
            chk("t1_o3_r", log_q[3].r, 2); chk("t1_o3_c", log_q[3].c, 2);
        end

        // Partial edge tiles
        run_seq(3, 5);
        chk("t2_count", log_q.size(), 6);
        if (log_q.size() == 6) begin
            chk("t2_last_r", log_q[5].r, 2);
            chk("t2_last_c", log_q[5].c, 4);
        end

        // Consumer stalls five cycles on tile index 1
        hold_tile = 1;
        hold_cnt  = 0;
        run_seq(4, 4);
        chk("t3_hold_applied", hold_cnt, 5);
        hold_tile = -1;

        // Empty matrices
        run_seq(3, 0);
        run_seq(0, 5);

        // Reset while waiting on tile 3
        rand_lat = 1;
        start_go(6, 6);
        n = 0;
        while (iss_idx < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_tile3", iss_idx, 3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        rand_lat = 0;
        run_seq(4, 4);
        chk("t5_restart_count", log_q.size(), 4);
        if (log_q.size() > 0) begin
            chk("t5_restart_r", log_q[0].r, 0);
            chk("t5_restart_c", log_q[0].c, 0);
        end

        // Randomized sequences with busy-time go noise, stalls and stale done pulses
        for (int i = 0; i < 25; i++) begin
            rand_lat   = $urandom % 2;
            rand_ready = $urandom % 2;
            stale_en   = $urandom % 2;
            noise      = 1;
            run_seq(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
        end
        noise = 0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
